// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the valid/ready pipeline stage: default bundle widths,
// the control NOP encoding and the steer selector for the main slot.
package pipe_stage_hs_pkg;

    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_DATA_W = 128;

    // Every stage instance presents this control value while it holds no valid beat.
    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_IN   = 2'd1,
        SRC_SKID = 2'd2
    } main_src_e;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register set: valid bit plus control and data bundles, with
// load and clear controls. Clearing forces the NOP control and keeps the data.
module pipe_slot
    import pipe_stage_hs_pkg::*;
#(
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: non-blocking assignments so every flop samples pre-edge values; clear is
    // checked before load so a flush wins over a beat arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with synchronous flush-to-bubble.
// Define PIPE_SKID_EN to add a skid slot and break the out_ready -> in_ready path.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              in_fire;
    logic              out_fire;
    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign in_fire  = hs_fire(in_valid, in_ready);
    assign out_fire = hs_fire(main_valid, out_ready);

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    main_src_e         main_src;

    // in_ready comes straight from the skid flop, so it never depends on out_ready.
    assign in_ready = ~skid_valid;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        main_src    = SRC_HOLD;
        main_d_ctrl = in_ctrl;
        main_d_data = in_data;
        if (out_fire && skid_valid) begin
            main_src    = SRC_SKID;
            main_d_ctrl = skid_ctrl;
            main_d_data = skid_data;
        end else if (in_fire && (!main_valid || out_fire)) begin
            main_src    = SRC_IN;
        end
        main_load  = (main_src != SRC_HOLD);
        main_clear = flush | (out_fire & (main_src == SRC_HOLD));
        skid_load  = in_fire & main_valid & ~out_fire;
        skid_clear = flush | (out_fire & skid_valid);
    end

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
    );
`else
    assign in_ready    = out_ready | ~main_valid;
    assign main_load   = in_fire;
    assign main_clear  = flush | (out_fire & ~in_fire);
    assign main_d_ctrl = in_ctrl;
    assign main_d_data = in_data;
`endif

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

endmodule
